// File: rtl/sdrc_bram_responder_if.sv
// sdrc_bram_responder_if: SDRAM controller user-side bus between ramio (master) and the responder (slave)
interface sdrc_bram_responder_if;
    logic        I_sdrc_cmd_en;
    logic [2:0]  I_sdrc_cmd;
    logic        I_sdrc_precharge_ctrl;
    logic        I_sdrc_power_down;
    logic        I_sdrc_selfrefresh;
    logic [20:0] I_sdrc_addr;
    logic [3:0]  I_sdrc_dqm;
    logic [31:0] I_sdrc_data;
    logic [7:0]  I_sdrc_data_len;
    logic [31:0] O_sdrc_data;
    logic        O_sdrc_init_done;
    logic        O_sdrc_cmd_ack;
    logic        protocol_error;

    modport master (
        output I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdrc_power_down,
               I_sdrc_selfrefresh, I_sdrc_addr, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len,
        input  O_sdrc_data, O_sdrc_init_done, O_sdrc_cmd_ack, protocol_error
    );

    modport slave (
        input  I_sdrc_cmd_en, I_sdrc_cmd, I_sdrc_precharge_ctrl, I_sdrc_power_down,
               I_sdrc_selfrefresh, I_sdrc_addr, I_sdrc_dqm, I_sdrc_data, I_sdrc_data_len,
        output O_sdrc_data, O_sdrc_init_done, O_sdrc_cmd_ack, protocol_error
    );
endinterface

// File: rtl/sdrc_bram_responder.sv
// sdrc_bram_responder: BRAM-backed stand-in for the SDRAM controller, reproducing its ack/burst timing
// AckLatency must be >= 1 and ReadLatency >= 2 (one cycle is the registered BRAM read).
module sdrc_bram_responder #(
    parameter int InitCycles      = 100,
    parameter int AckLatency      = 2,
    parameter int ReadLatency     = 3,
    parameter int MemAddrBitWidth = 12
) (
    input  logic clk,
    input  logic rst_n,
    sdrc_bram_responder_if.slave sdrc
);
    typedef enum logic [2:0] {INIT, IDLE, ACK_WAIT, BURST_WR, RD_WAIT, BURST_RD} state_t;

    state_t      state, state_nx;
    logic [15:0] cnt;
    logic [2:0]  cmd_q;
    logic [20:0] addr_q;
    logic [7:0]  len_q;
    logic        pre_q;
    logic [7:0]  col_q;
    logic [8:0]  beat_q;
    logic [3:0]  bank_open;
    logic [10:0] bank_row [4];
    logic        init_done_q, perr_q, rd_valid_q;
    logic [31:0] rd_q;
    logic [31:0] mem [2**MemAddrBitWidth];
    logic        ack, we, re, burst_end;

    wire [1:0] bank   = addr_q[20:19];
    wire       open   = bank_open[bank];
    wire       is_act = cmd_q == 3'b011;
    wire       is_rd  = cmd_q == 3'b101;
    wire       is_wr  = cmd_q == 3'b100;
    wire       is_pre = cmd_q == 3'b010;
    wire [7:0] wcol   = state == ACK_WAIT ? addr_q[7:0] : col_q;

    // Next state and per-cycle strobes; the ack cycle also carries write word 0
    always_comb begin
        state_nx  = state;
        ack       = 1'b0;
        we        = 1'b0;
        re        = 1'b0;
        burst_end = 1'b0;
        case (state)
            INIT:     state_nx = cnt == 16'(InitCycles - 1) ? IDLE : INIT;
            IDLE:     state_nx = sdrc.I_sdrc_cmd_en ? ACK_WAIT : IDLE;
            ACK_WAIT: if (cnt == 16'(AckLatency - 1)) begin
                ack       = 1'b1;
                we        = is_wr && open;
                burst_end = is_wr && len_q == 8'd0;
                state_nx  = (is_wr && len_q != 8'd0) ? BURST_WR :
                            is_rd ? (ReadLatency > 2 ? RD_WAIT : BURST_RD) : IDLE;
            end
            BURST_WR: begin
                we        = open;
                burst_end = beat_q == {1'b0, len_q};
                state_nx  = burst_end ? IDLE : BURST_WR;
            end
            RD_WAIT:  state_nx = cnt == 16'(ReadLatency - 2) ? BURST_RD : RD_WAIT;
            BURST_RD: begin
                burst_end = beat_q == {1'b0, len_q} + 9'd1;
                re        = !burst_end;
                state_nx  = burst_end ? IDLE : BURST_RD;
            end
            default:  state_nx = INIT;
        endcase
    end

    // State register; cnt restarts on every transition (at 1 when leaving the ack so RD_WAIT counts from the ack)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= state_nx != state ? 16'(state == ACK_WAIT) : cnt + 16'd1;
        end
    end

    // Command capture and burst column/beat tracking (column wraps inside the open row)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q  <= '0;
            addr_q <= '0;
            len_q  <= '0;
            pre_q  <= 1'b0;
            col_q  <= '0;
            beat_q <= '0;
        end else begin
            if (state == IDLE && sdrc.I_sdrc_cmd_en) begin
                cmd_q  <= sdrc.I_sdrc_cmd;
                addr_q <= sdrc.I_sdrc_addr;
                len_q  <= sdrc.I_sdrc_data_len;
                pre_q  <= sdrc.I_sdrc_precharge_ctrl;
            end
            if (ack) begin
                beat_q <= 9'(is_wr);
                col_q  <= addr_q[7:0] + 8'(is_wr);
            end else if (state == BURST_WR || state == BURST_RD) begin
                beat_q <= beat_q + 9'd1;
                col_q  <= col_q + 8'd1;
            end
        end
    end

    // Bank open/closed flags: ACT opens, PRE or an auto-precharged burst closes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bank_open <= '0;
        else if (ack && is_act)
            bank_open[bank] <= 1'b1;
        else if ((ack && is_pre) || (burst_end && pre_q))
            bank_open[bank] <= 1'b0;
    end

    // Open row per bank, only meaningful while its bank is open
    always_ff @(posedge clk) begin
        if (ack && is_act)
            bank_row[bank] <= addr_q[18:8];
    end

    // Status flags: init_done latches at the end of INIT; protocol_error is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_q <= 1'b0;
            perr_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            init_done_q <= init_done_q || (state == INIT && state_nx == IDLE);
            perr_q      <= perr_q || (sdrc.I_sdrc_cmd_en && state != IDLE) ||
                           ((sdrc.I_sdrc_power_down || sdrc.I_sdrc_selfrefresh) && state != INIT) ||
                           (ack && (is_rd || is_wr) && !open);
            rd_valid_q  <= re && open;
        end
    end

    // Block RAM: byte-masked write port and registered read port
    always_ff @(posedge clk) begin
        if (we)
            for (int i = 0; i < 4; i++)
                if (!sdrc.I_sdrc_dqm[i])
                    mem[MemAddrBitWidth'({bank, bank_row[bank], wcol})][8*i +: 8] <= sdrc.I_sdrc_data[8*i +: 8];
        rd_q <= mem[MemAddrBitWidth'({bank, bank_row[bank], col_q})];
    end

    assign sdrc.O_sdrc_cmd_ack   = ack;
    assign sdrc.O_sdrc_init_done = init_done_q;
    assign sdrc.O_sdrc_data      = rd_valid_q ? rd_q : '0;
    assign sdrc.protocol_error   = perr_q;
endmodule

// File: tb/tb_sdrc_bram_responder.sv
// tb_sdrc_bram_responder: directed checks of init, ack timing, bursts, masking, precharge and reset abort
module tb_sdrc_bram_responder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] wbuf [8];
    logic [31:0] ebuf [8];

    always #5 clk = ~clk;

    sdrc_bram_responder_if sdrc ();

    sdrc_bram_responder dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sdrc (sdrc)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_init();
        rst_n = 1'b0;
        tick();
        tick();
        check("rst_init_done", 32'(sdrc.O_sdrc_init_done), 0);
        check("rst_perr", 32'(sdrc.protocol_error), 0);
        check("rst_data", sdrc.O_sdrc_data, 0);
        rst_n = 1'b1;
        repeat (99) tick();
        check("init_done_99", 32'(sdrc.O_sdrc_init_done), 0);
        tick();
        check("init_done_100", 32'(sdrc.O_sdrc_init_done), 1);
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [20:0] a, input logic [7:0] len, input logic pre);
        sdrc.I_sdrc_cmd            = c;
        sdrc.I_sdrc_addr           = a;
        sdrc.I_sdrc_data_len       = len;
        sdrc.I_sdrc_precharge_ctrl = pre;
        sdrc.I_sdrc_cmd_en         = 1'b1;
        tick();
        sdrc.I_sdrc_cmd_en = 1'b0;
        check("ack_early", 32'(sdrc.O_sdrc_cmd_ack), 0);
        tick();
        check("ack", 32'(sdrc.O_sdrc_cmd_ack), 1);
    endtask

    task automatic act(input logic [1:0] b, input logic [10:0] r);
        do_cmd(3'b011, {b, r, 8'h00}, 8'd0, 1'b0);
        tick();
        check("act_ack_pulse", 32'(sdrc.O_sdrc_cmd_ack), 0);
    endtask

    task automatic wr(input logic [20:0] a, input int len, input logic [3:0] m);
        sdrc.I_sdrc_dqm = m;
        do_cmd(3'b100, a, 8'(len), 1'b0);
        for (int k = 0; k <= len; k++) begin
            sdrc.I_sdrc_data = wbuf[k];
            tick();
            if (k == 0) check("wr_ack_pulse", 32'(sdrc.O_sdrc_cmd_ack), 0);
        end
        sdrc.I_sdrc_dqm  = 4'h0;
        sdrc.I_sdrc_data = 32'h0;
    endtask

    task automatic rd(input logic [20:0] a, input int len, input logic pre);
        do_cmd(3'b101, a, 8'(len), pre);
        tick();
        tick();
        check("rd_before", sdrc.O_sdrc_data, 0);
        tick();
        for (int k = 0; k <= len; k++) begin
            check($sformatf("rd_word%0d", k), sdrc.O_sdrc_data, ebuf[k]);
            tick();
        end
        check("rd_after", sdrc.O_sdrc_data, 0);
    endtask

    initial begin
        sdrc.I_sdrc_cmd_en         = 1'b0;
        sdrc.I_sdrc_cmd            = 3'b111;
        sdrc.I_sdrc_precharge_ctrl = 1'b0;
        sdrc.I_sdrc_power_down     = 1'b0;
        sdrc.I_sdrc_selfrefresh    = 1'b0;
        sdrc.I_sdrc_addr           = '0;
        sdrc.I_sdrc_dqm            = 4'h0;
        sdrc.I_sdrc_data           = '0;
        sdrc.I_sdrc_data_len       = '0;
        tick();
        tick();
        check("por_init_done", 32'(sdrc.O_sdrc_init_done), 0);
        check("por_ack", 32'(sdrc.O_sdrc_cmd_ack), 0);
        check("por_data", sdrc.O_sdrc_data, 0);
        check("por_perr", 32'(sdrc.protocol_error), 0);
        rst_n = 1'b1;
        repeat (49) tick();
        sdrc.I_sdrc_cmd_en = 1'b1;
        tick();
        sdrc.I_sdrc_cmd_en = 1'b0;
        check("init_ack_none", 32'(sdrc.O_sdrc_cmd_ack), 0);
        repeat (49) tick();
        check("t1_init_99", 32'(sdrc.O_sdrc_init_done), 0);
        tick();
        check("t1_init_100", 32'(sdrc.O_sdrc_init_done), 1);
        check("t1_perr_init_cmd", 32'(sdrc.protocol_error), 1);

        reset_init();

        act(2'd1, 11'h005);
        for (int k = 0; k < 4; k++) wbuf[k] = 32'hA000_0000 | 32'(k);
        wr({2'd1, 11'h005, 8'h10}, 3, 4'h0);
        for (int k = 0; k < 4; k++) ebuf[k] = 32'hA000_0000 | 32'(k);
        rd({2'd1, 11'h005, 8'h10}, 3, 1'b0);

        for (int k = 0; k < 4; k++) wbuf[k] = 32'hB000_0000 | 32'(k);
        wr({2'd1, 11'h005, 8'hFE}, 3, 4'h0);
        for (int k = 0; k < 4; k++) ebuf[k] = 32'hB000_0000 | 32'(k);
        rd({2'd1, 11'h005, 8'hFE}, 3, 1'b0);
        ebuf[0] = 32'hB000_0002;
        ebuf[1] = 32'hB000_0003;
        rd({2'd1, 11'h005, 8'h00}, 1, 1'b0);

        wbuf[0] = 32'h1122_3344;
        wr({2'd1, 11'h005, 8'h20}, 0, 4'h0);
        wbuf[0] = 32'hDEAD_BEEF;
        wr({2'd1, 11'h005, 8'h20}, 0, 4'b0101);
        ebuf[0] = 32'hDE22_BE44;
        rd({2'd1, 11'h005, 8'h20}, 0, 1'b0);
        check("perr_clean", 32'(sdrc.protocol_error), 0);

        ebuf[0] = 32'hA000_0000;
        rd({2'd1, 11'h005, 8'h10}, 0, 1'b1);
        check("perr_before_closed", 32'(sdrc.protocol_error), 0);
        ebuf[0] = 32'h0;
        rd({2'd1, 11'h005, 8'h10}, 0, 1'b0);
        check("perr_closed_rd", 32'(sdrc.protocol_error), 1);

        reset_init();
        act(2'd1, 11'h005);
        do_cmd(3'b101, {2'd1, 11'h005, 8'h10}, 8'd7, 1'b0);
        repeat (3) tick();
        check("t6_word0", sdrc.O_sdrc_data, 32'hA000_0000);
        tick();
        check("t6_word1", sdrc.O_sdrc_data, 32'hA000_0001);
        tick();
        check("t6_word2", sdrc.O_sdrc_data, 32'hA000_0002);
        rst_n = 1'b0;
        #1;
        check("t6_abort_data", sdrc.O_sdrc_data, 0);
        check("t6_abort_init", 32'(sdrc.O_sdrc_init_done), 0);
        check("t6_abort_ack", 32'(sdrc.O_sdrc_cmd_ack), 0);
        reset_init();

        sdrc.I_sdrc_power_down = 1'b1;
        tick();
        sdrc.I_sdrc_power_down = 1'b0;
        tick();
        check("perr_power_down", 32'(sdrc.protocol_error), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
